pipe_register_file: RTL and testbench
=====================================

PIPE_REGISTER_FILE -- requirements
Module: pipe_register_file

Interface
REQ-001 SHALL provide parameter XLEN, default 32: data width in bits.
REQ-002 SHALL provide parameter NREGS, default 32: register count, a power of two, at least 2.
REQ-003 SHALL provide parameter NREAD, default 2: read port count, at least 1.
REQ-004 SHALL derive local constant AW = log2(NREGS) as the address width.
REQ-005 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-006 SHALL have port reset_n, input, 1 bit: reset, asynchronous, active-low.
REQ-007 SHALL have port in_read_address, input, NREAD*AW bits: read addresses; port k occupies slice [k*AW +: AW].
REQ-008 SHALL have port out_read_data, output, NREAD*XLEN bits: read data, per-port slices in the same order.
REQ-009 SHALL have port out_read_busy, output, NREAD bits: per-port pending-write (busy) flag.
REQ-010 SHALL have port in_write_enable, input, 1 bit: writeback strobe.
REQ-011 SHALL have port in_write_address, input, AW bits: writeback destination.
REQ-012 SHALL have port in_write_data, input, XLEN bits: writeback data.
REQ-013 SHALL have port in_reserve_enable, input, 1 bit: issue-time destination reservation strobe.
REQ-014 SHALL have port in_reserve_address, input, AW bits: register to mark busy.
REQ-015 SHALL have port in_flush, input, 1 bit: synchronous clear of all busy bits.
REQ-016 SHALL have port out_busy_count, output, AW+1 bits: number of busy registers.

Function
REQ-017 SHALL keep register 0 reading as zero, never writable and never busy; writes and reserves to address 0 are ignored.
REQ-018 SHALL perform reads combinationally with zero-cycle latency on every port, independently of the other ports.
REQ-019 SHALL, on a clk edge with in_write_enable=1 and a nonzero address, store in_write_data and clear that register's busy bit.
REQ-020 SHALL, on a clk edge with in_reserve_enable=1 and a nonzero address, set that register's busy bit.
REQ-021 SHALL give reserve priority when a write and a reserve target the same register on the same edge: data is stored and the busy bit ends at 1.
REQ-022 SHALL give in_flush priority over reserve and write-clear: all busy bits become 0, the count becomes 0, and any write data is still stored.
REQ-023 SHALL increment out_busy_count by 1 per edge when a 0->1 busy transition occurs and decrement it by 1 when a 1->0 transition occurs; it SHALL be unchanged when both occur on the same edge.
REQ-024 SHALL keep out_busy_count at or below NREGS-1 (register 0 is never busy), so it never wraps.
REQ-025 SHALL treat a write to a register that is not busy as a normal write, with busy remaining 0.
REQ-026 SHALL treat a reserve of an already-busy register as a no-op on both the busy bit and the count.

Reset
REQ-027 SHALL, while reset_n=0, asynchronously clear all registers to 0, all busy bits to 0 and out_busy_count to 0.
REQ-028 SHALL, when reset_n is asserted mid-operation, take effect immediately and discard any writes or reserves presented on that cycle.
REQ-029 SHALL, after reset is released, produce out_read_data=0 and out_read_busy=0 on all ports.

Configuration
REQ-030 SHALL use macro REGFILE_BYPASS_EN to control write-to-read forwarding.
REQ-031 SHALL, when REGFILE_BYPASS_EN is defined and a read port address equals a nonzero in_write_address with in_write_enable=1, present in_write_data on that port with busy=0 in the same cycle.
REQ-032 SHALL, when REGFILE_BYPASS_EN is undefined, present the stored value and stored busy bit; the new data becomes visible the cycle after the edge.

Structure
REQ-033 SHALL place the default XLEN/NREGS/NREAD values and the XLEN-wide zero constant in the shared package riscv_pkg.
REQ-034 SHALL implement the busy bits and the counter in one sub-module, regfile_scoreboard; the data array, read muxes and bypass SHALL stay in the top level.

Verification
REQ-035 SHALL cover: reset, then read addresses 0/5/31 -> data 0, busy 0, count 0.
REQ-036 SHALL cover: reserve x5 -> busy[x5]=1, count=1; then write x5=0xDEADBEEF -> busy 0, count 0, read returns 0xDEADBEEF.
REQ-037 SHALL cover: write and reserve x7 on the same edge -> data stored, busy[x7]=1, count +1.
REQ-038 SHALL cover: write x0=0x1234 and reserve x0 -> reads 0, busy 0, count unchanged.
REQ-039 SHALL cover: reserve x1..x3, then flush concurrent with reserve x4 -> count 0, all busy 0.
REQ-040 SHALL cover: with in_write_enable=1, write x9=0xA5A5A5A5 while reading x9 in the same cycle -> REGFILE_BYPASS_EN defined: 0xA5A5A5A5 that cycle; undefined: old value that cycle, new value the next cycle.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared constants for the pipeline register file: default geometry and the
// register-width zero value.
package riscv_pkg;

    localparam int XLEN_DEFAULT  = 32;
    localparam int NREGS_DEFAULT = 32;
    localparam int NREAD_DEFAULT = 2;

    localparam logic [XLEN_DEFAULT-1:0] XLEN_ZERO = '0;

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard for the register file: reservations set a bit, writebacks
// clear it, flush clears all; a running count of busy registers is kept.
module regfile_scoreboard #(
    parameter int NREGS = 32,
    localparam int AW = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             write_enable,
    input  logic [AW-1:0]    write_address,
    input  logic             reserve_enable,
    input  logic [AW-1:0]    reserve_address,
    input  logic             flush,
    output logic [NREGS-1:0] busy,
    output logic [AW:0]      busy_count
);

    logic             set_hit;
    logic             clr_hit;
    logic [NREGS-1:0] busy_next;
    logic [AW:0]      count_next;

    // A reserve to the register being written wins, so that write never clears.
    assign set_hit = reserve_enable && (reserve_address != '0) && !busy[reserve_address];
    assign clr_hit = write_enable && (write_address != '0) && busy[write_address] &&
                     !(reserve_enable && (reserve_address == write_address));

    always_comb begin
        busy_next = busy;
        if (clr_hit) begin
            busy_next[write_address] = 1'b0;
        end
        if (set_hit) begin
            busy_next[reserve_address] = 1'b1;
        end
    end

    always_comb begin
        count_next = busy_count;
        if (set_hit && !clr_hit) begin
            count_next = busy_count + (AW+1)'(1);
        end else if (clr_hit && !set_hit) begin
            count_next = busy_count - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy       <= '0;
            busy_count <= '0;
        end else if (flush) begin
            busy       <= '0;
            busy_count <= '0;
        end else begin
            busy       <= busy_next;
            busy_count <= count_next;
        end
    end

endmodule

// File: rtl/pipe_register_file.sv
// Pipeline register file with per-register busy tracking and NREAD combinational
// read ports. Define REGFILE_BYPASS_EN to forward same-cycle writeback data to reads.
module pipe_register_file
    import riscv_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int NREGS = NREGS_DEFAULT,
    parameter int NREAD = NREAD_DEFAULT,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [NREAD*AW-1:0]   in_read_address,
    output logic [NREAD*XLEN-1:0] out_read_data,
    output logic [NREAD-1:0]      out_read_busy,
    input  logic                  in_write_enable,
    input  logic [AW-1:0]         in_write_address,
    input  logic [XLEN-1:0]       in_write_data,
    input  logic                  in_reserve_enable,
    input  logic [AW-1:0]         in_reserve_address,
    input  logic                  in_flush,
    output logic [AW:0]           out_busy_count
);

    logic [XLEN-1:0]  regs [NREGS];
    logic [NREGS-1:0] busy;

    regfile_scoreboard #(
        .NREGS (NREGS)
    ) u_scoreboard (
        .clk             (clk),
        .reset_n         (reset_n),
        .write_enable    (in_write_enable),
        .write_address   (in_write_address),
        .reserve_enable  (in_reserve_enable),
        .reserve_address (in_reserve_address),
        .flush           (in_flush),
        .busy            (busy),
        .busy_count      (out_busy_count)
    );

    // Flush does not gate the data write; only the busy bits are discarded.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= XLEN'(XLEN_ZERO);
            end
        end else if (in_write_enable && (in_write_address != '0)) begin
            regs[in_write_address] <= in_write_data;
        end
    end

    for (genvar k = 0; k < NREAD; k++) begin : g_read
        logic [AW-1:0] rd_addr;
        assign rd_addr = in_read_address[k*AW +: AW];

        always_comb begin
            out_read_data[k*XLEN +: XLEN] = XLEN'(XLEN_ZERO);
            out_read_busy[k]              = 1'b0;
            if (rd_addr != '0) begin
`ifdef REGFILE_BYPASS_EN
                if (in_write_enable && (in_write_address == rd_addr)) begin
                    out_read_data[k*XLEN +: XLEN] = in_write_data;
                end else begin
                    out_read_data[k*XLEN +: XLEN] = regs[rd_addr];
                    out_read_busy[k]              = busy[rd_addr];
                end
`else
                out_read_data[k*XLEN +: XLEN] = regs[rd_addr];
                out_read_busy[k]              = busy[rd_addr];
`endif
            end
        end
    end

endmodule

// File: tb/tb_pipe_register_file.sv
// Self-checking bench for pipe_register_file (default geometry); honours REGFILE_BYPASS_EN.
module tb_pipe_register_file;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int NREAD = 2;
    localparam int AW    = 5;

    logic                  clk;
    logic                  reset_n;
    logic [NREAD*AW-1:0]   in_read_address;
    logic [NREAD*XLEN-1:0] out_read_data;
    logic [NREAD-1:0]      out_read_busy;
    logic                  in_write_enable;
    logic [AW-1:0]         in_write_address;
    logic [XLEN-1:0]       in_write_data;
    logic                  in_reserve_enable;
    logic [AW-1:0]         in_reserve_address;
    logic                  in_flush;
    logic [AW:0]           out_busy_count;

    pipe_register_file #(
        .XLEN  (XLEN),
        .NREGS (NREGS),
        .NREAD (NREAD)
    ) dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .in_read_address    (in_read_address),
        .out_read_data      (out_read_data),
        .out_read_busy      (out_read_busy),
        .in_write_enable    (in_write_enable),
        .in_write_address   (in_write_address),
        .in_write_data      (in_write_data),
        .in_reserve_enable  (in_reserve_enable),
        .in_reserve_address (in_reserve_address),
        .in_flush           (in_flush),
        .out_busy_count     (out_busy_count)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model
    logic [XLEN-1:0]  m_regs [NREGS];
    logic [NREGS-1:0] m_busy;
    logic [XLEN:0]    exp_q [$];

    int n_vectors     = 0;
    int n_miscompares = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vectors++;
        if (got !== exp) begin
            n_miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NREGS; i++) m_regs[i] = '0;
        m_busy = '0;
    endtask

    function automatic logic [XLEN:0] exp_read(input logic [AW-1:0] addr);
        if (addr == '0) return '0;
`ifdef REGFILE_BYPASS_EN
        if (in_write_enable && in_write_address == addr) return {1'b0, in_write_data};
`endif
        return {m_busy[addr], m_regs[addr]};
    endfunction

    // driver tasks
    task automatic apply(input logic we, input logic [AW-1:0] wa, input logic [XLEN-1:0] wd,
                         input logic re, input logic [AW-1:0] ra, input logic fl);
        in_write_enable    = we;
        in_write_address   = wa;
        in_write_data      = wd;
        in_reserve_enable  = re;
        in_reserve_address = ra;
        in_flush           = fl;
    endtask

    task automatic commit();
        logic [NREGS-1:0] nb;
        @(posedge clk);
        nb = m_busy;
        if (in_write_enable && in_write_address != '0) begin
            m_regs[in_write_address] = in_write_data;
            nb[in_write_address] = 1'b0;
        end
        if (in_reserve_enable && in_reserve_address != '0) nb[in_reserve_address] = 1'b1;
        if (in_flush) nb = '0;
        m_busy = nb;
        #1;
        apply(1'b0, '0, '0, 1'b0, '0, 1'b0);
    endtask

    task automatic cycle(input logic we, input logic [AW-1:0] wa, input logic [XLEN-1:0] wd,
                         input logic re, input logic [AW-1:0] ra, input logic fl);
        apply(we, wa, wd, re, ra, fl);
        commit();
    endtask

    task automatic read_check(input int port, input logic [AW-1:0] addr, input string tag);
        logic [XLEN:0] got;
        logic [XLEN:0] exp;
        in_read_address[port*AW +: AW] = addr;
        exp_q.push_back(exp_read(addr));
        #1;
        got = {out_read_busy[port], out_read_data[port*XLEN +: XLEN]};
        exp = exp_q.pop_front();
        check($sformatf("%s p%0d x%0d", tag, port, addr), 64'(got), 64'(exp));
    endtask

    task automatic count_check(input string tag);
        check(tag, 64'(out_busy_count), 64'($countones(m_busy)));
    endtask

    initial begin
        reset_n         = 1'b0;
        in_read_address = '0;
        apply(1'b0, '0, '0, 1'b0, '0, 1'b0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        count_check("count_in_reset");
        reset_n = 1'b1;

        // reset state
        for (int p = 0; p < NREAD; p++) begin
            read_check(p, 5'd0, "rst");
            read_check(p, 5'd5, "rst");
            read_check(p, 5'd31, "rst");
        end
        count_check("count_after_reset");

        // reserve then writeback
        cycle(1'b0, '0, '0, 1'b1, 5'd5, 1'b0);
        read_check(0, 5'd5, "reserved");
        check("count_res5", 64'(out_busy_count), 64'd1);
        cycle(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, 1'b0);
        read_check(1, 5'd5, "written");
        check("count_wb5", 64'(out_busy_count), 64'd0);

        // write and reserve same register
        cycle(1'b1, 5'd7, 32'h7777_0007, 1'b1, 5'd7, 1'b0);
        read_check(0, 5'd7, "wr_res_same");
        check("count_x7", 64'(out_busy_count), 64'd1);

        // register 0 is immutable
        cycle(1'b1, 5'd0, 32'h1234, 1'b1, 5'd0, 1'b0);
        read_check(0, 5'd0, "x0");
        read_check(1, 5'd0, "x0");
        check("count_x0", 64'(out_busy_count), 64'd1);

        // reserve of already-busy register, write to idle register
        cycle(1'b0, '0, '0, 1'b1, 5'd7, 1'b0);
        count_check("re_reserve");
        cycle(1'b1, 5'd12, 32'h0C0C_0C0C, 1'b0, '0, 1'b0);
        read_check(0, 5'd12, "idle_write");

        // flush beats a concurrent reserve
        for (int r = 1; r <= 3; r++) cycle(1'b0, '0, '0, 1'b1, AW'(r), 1'b0);
        count_check("count_pre_flush");
        cycle(1'b0, '0, '0, 1'b1, 5'd4, 1'b1);
        check("count_flush", 64'(out_busy_count), 64'd0);
        for (int r = 1; r <= 4; r++) read_check(r % NREAD, AW'(r), "flush");
        read_check(0, 5'd7, "flush");

        // same-cycle read of the register being written
        cycle(1'b1, 5'd9, 32'h1111_1111, 1'b0, '0, 1'b0);
        apply(1'b1, 5'd9, 32'hA5A5A5A5, 1'b0, '0, 1'b0);
        read_check(0, 5'd9, "bypass_same");
`ifdef REGFILE_BYPASS_EN
        check("bypass_value", 64'(out_read_data[XLEN-1:0]), 64'hA5A5A5A5);
`else
        check("bypass_value", 64'(out_read_data[XLEN-1:0]), 64'h1111_1111);
`endif
        commit();
        read_check(1, 5'd9, "bypass_next");

        // random traffic, reads checked while the writeback is still presented
        for (int n = 0; n < 300; n++) begin
            apply(1'($urandom_range(0, 1)), AW'($urandom_range(0, NREGS-1)), $urandom,
                  1'($urandom_range(0, 1)), AW'($urandom_range(0, NREGS-1)),
                  ($urandom_range(0, 19) == 0));
            read_check(0, AW'($urandom_range(0, NREGS-1)), "rand");
            read_check(1, (n % 4 == 0) ? in_write_address : AW'($urandom_range(0, NREGS-1)), "rand");
            commit();
            count_check("rand_count");
        end

        // reset asserted mid-operation discards the presented write/reserve
        for (int r = 20; r < 24; r++) cycle(1'b1, AW'(r), 32'hCAFE_0000 + r, 1'b1, AW'(r + 4), 1'b0);
        apply(1'b1, 5'd3, 32'hBAD0_BAD0, 1'b1, 5'd6, 1'b0);
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        count_check("count_async_rst");
        @(posedge clk);
        #1;
        apply(1'b0, '0, '0, 1'b0, '0, 1'b0);
        reset_n = 1'b1;
        read_check(0, 5'd3, "midrst");
        read_check(1, 5'd6, "midrst");
        read_check(0, 5'd21, "midrst");
        read_check(1, 5'd25, "midrst");
        count_check("count_midrst");

        if (exp_q.size() != 0) check("exp_q_drained", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
